// File: rtl/div_unit_rv.sv
// Multi-cycle restoring divider for the RISC-V M divide ops (DIV, DIVU, REM, REMU).
// Divide-by-zero, signed overflow and |a| < |b| finish in the start cycle; everything else iterates.
//
// state  | meaning
// S_IDLE | waiting for start; special cases complete here without leaving
// S_CALC | BITS_PER_CYCLE restoring steps per edge, counter runs ITER..1
// S_FIX  | sign correction, result registers loaded, done pulse
module div_unit_rv #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter bit FAST_PATH      = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_o,
    output logic             dbz_o,
    output logic             ovf_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             op_rem_q;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             sgn_ovf;
    logic             fast;
    logic             quick;
    logic             accept;
    logic [WIDTH-1:0] quick_quo;
    logic [WIDTH-1:0] quick_rem;

    assign busy_o    = (state_q != S_IDLE);
    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & dividend_i[WIDTH-1];
    assign b_neg     = is_signed & divisor_i[WIDTH-1];
    // The negation of MIN wraps to 2^(WIDTH-1), which is exactly its magnitude as unsigned.
    assign a_mag     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign b_mag     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign sgn_ovf   = is_signed & (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor_i);
    assign fast      = FAST_PATH & (a_mag < b_mag);
    assign quick     = div_zero | sgn_ovf | fast;
    assign accept    = start_i & ~busy_o & ~kill_i;

    always_comb begin
        quick_quo = '0;
        quick_rem = dividend_i;
        if (div_zero) begin
            quick_quo = '1;
            quick_rem = dividend_i;
        end else if (sgn_ovf) begin
            quick_quo = dividend_i;
            quick_rem = '0;
        end
    end

    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] quo_n;

    always_comb begin
        rem_n = rem_q;
        quo_n = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_n = {rem_n[WIDTH-1:0], quo_n[WIDTH-1]};
            quo_n = {quo_n[WIDTH-2:0], 1'b0};
            if (rem_n >= {1'b0, dvs_q}) begin
                rem_n    = rem_n - {1'b0, dvs_q};
                quo_n[0] = 1'b1;
            end
        end
    end

    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            op_rem_q    <= 1'b0;
            done_o      <= 1'b0;
            valid_o     <= 1'b0;
            dbz_o       <= 1'b0;
            ovf_o       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            result_o    <= '0;
        end else begin
            done_o <= 1'b0;
            dbz_o  <= 1'b0;
            ovf_o  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (quick) begin
                            done_o      <= 1'b1;
                            valid_o     <= 1'b1;
                            dbz_o       <= div_zero;
                            ovf_o       <= sgn_ovf & ~div_zero;
                            quotient_o  <= quick_quo;
                            remainder_o <= quick_rem;
                            result_o    <= op_i[1] ? quick_rem : quick_quo;
                        end else begin
                            state_q   <= S_CALC;
                            cnt_q     <= CW'(ITER);
                            valid_o   <= 1'b0;
                            rem_q     <= '0;
                            quo_q     <= a_mag;
                            dvs_q     <= b_mag;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            op_rem_q  <= op_i[1];
                        end
                    end
                end
                S_CALC: begin
                    if (kill_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        rem_q <= rem_n;
                        quo_q <= quo_n;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    if (!kill_i) begin
                        done_o      <= 1'b1;
                        valid_o     <= 1'b1;
                        quotient_o  <= quo_fix;
                        remainder_o <= rem_fix;
                        result_o    <= op_rem_q ? rem_fix : quo_fix;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
